// File: rtl/key_search_pkg.sv
// Shared types and constants for the key_search brute-force controller.
//   state_t      : top-level key iteration / arc4 handshake states
//   scan_state_t : plaintext scanner states (RD_LEN .. CHK_BYTE)
//   KEY_W        : candidate key width
//   PT_LEN_ADDR  : plaintext memory address holding the length prefix
//   ASCII_*_DEF  : default printable-byte bounds
package key_search_pkg;

  localparam int unsigned KEY_W         = 24;
  localparam logic [7:0]  PT_LEN_ADDR   = 8'd0;
  localparam logic [7:0]  ASCII_MIN_DEF = 8'h20;
  localparam logic [7:0]  ASCII_MAX_DEF = 8'h7E;

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_WAIT_BUSY,
    S_WAIT_DONE,
    S_SCAN,
    S_NEXT_KEY,
    S_FOUND,
    S_DONE
  } state_t;

  typedef enum logic [2:0] {
    SC_IDLE,
    SC_RD_LEN,
    SC_LATCH_LEN,
    SC_RD_BYTE,
    SC_CHK_BYTE
  } scan_state_t;

  function automatic logic in_range(input logic [7:0] b,
                                    input logic [7:0] lo,
                                    input logic [7:0] hi);
    return (b >= lo) && (b <= hi);
  endfunction

endpackage

// File: rtl/key_search_scanner.sv
// pt_scanner: walks the length-prefixed plaintext left by arc4 and reports
// whether every byte lies within [ASCII_MIN, ASCII_MAX].
// Ports:
//   clk, rst   : clock, asynchronous active-high reset
//   start      : one-cycle pulse, begins a scan from the length byte
//   pt_rddata  : registered memory data, valid one cycle after pt_addr
//   pt_addr    : plaintext read address
//   done       : one-cycle pulse when the verdict is available
//   pass       : qualifies done; 1 = all bytes printable (or len = 0)
module pt_scanner
  import key_search_pkg::*;
#(
  parameter logic [7:0] ASCII_MIN = ASCII_MIN_DEF,
  parameter logic [7:0] ASCII_MAX = ASCII_MAX_DEF
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [7:0] pt_rddata,
  output logic [7:0] pt_addr,
  output logic       done,
  output logic       pass
);

  scan_state_t r_state, w_state_nxt;
  // 9 bits so that len = 255 terminates on idx == len without wrapping
  logic [8:0]  r_idx, w_idx_nxt;
  logic [7:0]  r_len, w_len_nxt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= SC_IDLE;
      r_idx   <= '0;
      r_len   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_idx   <= w_idx_nxt;
      r_len   <= w_len_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_idx_nxt   = r_idx;
    w_len_nxt   = r_len;
    pt_addr     = PT_LEN_ADDR;
    done        = 1'b0;
    pass        = 1'b0;
    case (r_state)
      SC_IDLE: begin
        if (start) w_state_nxt = SC_RD_LEN;
      end
      SC_RD_LEN: begin
        pt_addr     = PT_LEN_ADDR;
        w_state_nxt = SC_LATCH_LEN;
      end
      SC_LATCH_LEN: begin
        w_len_nxt = pt_rddata;
        w_idx_nxt = 9'd1;
        if (pt_rddata == 8'd0) begin
          done        = 1'b1;
          pass        = 1'b1;
          w_state_nxt = SC_IDLE;
        end else begin
          w_state_nxt = SC_RD_BYTE;
        end
      end
      SC_RD_BYTE: begin
        pt_addr     = r_idx[7:0];
        w_state_nxt = SC_CHK_BYTE;
      end
      SC_CHK_BYTE: begin
        pt_addr = r_idx[7:0];
        if (!in_range(pt_rddata, ASCII_MIN, ASCII_MAX)) begin
          done        = 1'b1;
          w_state_nxt = SC_IDLE;
        end else if (r_idx == {1'b0, r_len}) begin
          done        = 1'b1;
          pass        = 1'b1;
          w_state_nxt = SC_IDLE;
        end else begin
          w_idx_nxt   = r_idx + 9'd1;
          w_state_nxt = SC_RD_BYTE;
        end
      end
      default: w_state_nxt = SC_IDLE;
    endcase
  end

endmodule

// File: rtl/key_search.sv
// key_search: brute-force key iterator driving the arc4 core. Each candidate
// key is run through arc4, then the plaintext is scanned for printable ASCII.
// Stops at the first passing key or when the range is exhausted.
// Ports:
//   clk, rst   : clock, asynchronous active-high reset
//   en / rdy   : start request, accepted only while rdy = 1
//   key        : current candidate; the found key when key_valid = 1 in DONE
//   key_valid  : high in DONE when a key was found
//   arc4_en    : one-cycle start pulse to arc4
//   arc4_rdy   : arc4 idle/ready
//   arc4_key   : key presented to arc4 (always equals key)
//   pt_addr    : plaintext read address
//   pt_rddata  : plaintext read data (one-cycle read latency)
//   keys_tried : number of arc4 runs in the current search
//                (only with KEY_SEARCH_STATS_EN defined)
module key_search
  import key_search_pkg::*;
#(
  parameter logic [KEY_W-1:0] KEY_START = '0,
  parameter logic [KEY_W-1:0] KEY_END   = '1,
  parameter logic [KEY_W-1:0] KEY_STEP  = 24'd1,
  parameter logic [7:0]       ASCII_MIN = ASCII_MIN_DEF,
  parameter logic [7:0]       ASCII_MAX = ASCII_MAX_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  output logic             rdy,
  output logic [KEY_W-1:0] key,
  output logic             key_valid,
  output logic             arc4_en,
  input  logic             arc4_rdy,
  output logic [KEY_W-1:0] arc4_key,
  output logic [7:0]       pt_addr,
  input  logic [7:0]       pt_rddata
`ifdef KEY_SEARCH_STATS_EN
  ,
  output logic [24:0]      keys_tried
`endif
);

  state_t           r_state, w_state_nxt;
  logic [KEY_W-1:0] r_key, w_key_nxt;
  logic             r_key_valid, w_key_valid_nxt;
  logic             w_scan_start, w_scan_done, w_scan_pass;
  logic [KEY_W:0]   w_sum;
  logic             w_exhausted;

  assign key       = r_key;
  assign arc4_key  = r_key;
  assign key_valid = r_key_valid;

  // Extra carry bit keeps KEY_END = 24'hFFFFFF from wrapping back to 0
  assign w_sum       = {1'b0, r_key} + {1'b0, KEY_STEP};
  assign w_exhausted = w_sum[KEY_W] || (w_sum[KEY_W-1:0] > KEY_END);

  pt_scanner #(
    .ASCII_MIN (ASCII_MIN),
    .ASCII_MAX (ASCII_MAX)
  ) u_scan (
    .clk       (clk),
    .rst       (rst),
    .start     (w_scan_start),
    .pt_rddata (pt_rddata),
    .pt_addr   (pt_addr),
    .done      (w_scan_done),
    .pass      (w_scan_pass)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_key       <= KEY_START;
      r_key_valid <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_key       <= w_key_nxt;
      r_key_valid <= w_key_valid_nxt;
    end
  end

  always_comb begin
    w_state_nxt     = r_state;
    w_key_nxt       = r_key;
    w_key_valid_nxt = r_key_valid;
    rdy             = 1'b0;
    arc4_en         = 1'b0;
    w_scan_start    = 1'b0;
    case (r_state)
      S_IDLE, S_DONE: begin
        rdy = 1'b1;
        if (en) begin
          w_state_nxt     = S_START;
          w_key_nxt       = KEY_START;
          w_key_valid_nxt = 1'b0;
        end
      end
      S_START: begin
        if (arc4_rdy) begin
          arc4_en     = 1'b1;
          w_state_nxt = S_WAIT_BUSY;
        end
      end
      S_WAIT_BUSY: begin
        if (!arc4_rdy) w_state_nxt = S_WAIT_DONE;
      end
      S_WAIT_DONE: begin
        if (arc4_rdy) begin
          w_scan_start = 1'b1;
          w_state_nxt  = S_SCAN;
        end
      end
      S_SCAN: begin
        if (w_scan_done) w_state_nxt = w_scan_pass ? S_FOUND : S_NEXT_KEY;
      end
      S_NEXT_KEY: begin
        if (w_exhausted) begin
          w_state_nxt = S_DONE;
        end else begin
          w_key_nxt   = w_sum[KEY_W-1:0];
          w_state_nxt = S_START;
        end
      end
      S_FOUND: begin
        w_key_valid_nxt = 1'b1;
        w_state_nxt     = S_DONE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

`ifdef KEY_SEARCH_STATS_EN
  logic [24:0] r_keys_tried;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_keys_tried <= '0;
    end else if (rdy && en) begin
      r_keys_tried <= '0;
    end else if (arc4_en) begin
      r_keys_tried <= r_keys_tried + 25'd1;
    end
  end

  assign keys_tried = r_keys_tried;
`endif

endmodule

// File: tb/tb_key_search.sv
// Testbench for key_search: four instances with different key ranges, each
// driven by a behavioural arc4 + registered plaintext memory model. Expected
// results come from a search model iterating the candidate keys directly.
module tb_key_search;

  localparam int N = 4;
  localparam logic [23:0] P_START [N] = '{24'h000000, 24'h000005, 24'hFFFFFE, 24'h000001};
  localparam logic [23:0] P_END   [N] = '{24'hFFFFFF, 24'hFFFFFF, 24'hFFFFFF, 24'h00000B};
  localparam logic [23:0] P_STEP  [N] = '{24'd1, 24'd1, 24'd1, 24'd2};

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic        en_w    [N];
  logic        rdy_w   [N];
  logic        kv_w    [N];
  logic        a4en_w  [N];
  logic        a4rdy   [N];
  logic [23:0] key_w   [N];
  logic [23:0] a4key_w [N];
  logic [7:0]  addr_w  [N];
  logic [7:0]  rd_w    [N];
`ifdef KEY_SEARCH_STATS_EN
  logic [24:0] kt_w    [N];
`endif

  // plaintext per instance for keys 0..63; larger keys always fail
  logic [7:0]  ptab [N][64][256];
  int          pulses  [N];
  int          busy    [N];
  logic [23:0] run_key [N];
  logic [23:0] tried3 [$];

  int n_checks = 0;
  int n_errors = 0;

  for (genvar g = 0; g < N; g++) begin : g_dut
    key_search #(
      .KEY_START (P_START[g]),
      .KEY_END   (P_END[g]),
      .KEY_STEP  (P_STEP[g]),
      .ASCII_MIN (8'h20),
      .ASCII_MAX (8'h7E)
    ) u_dut (
      .clk       (clk),
      .rst       (rst),
      .en        (en_w[g]),
      .rdy       (rdy_w[g]),
      .key       (key_w[g]),
      .key_valid (kv_w[g]),
      .arc4_en   (a4en_w[g]),
      .arc4_rdy  (a4rdy[g]),
      .arc4_key  (a4key_w[g]),
      .pt_addr   (addr_w[g]),
      .pt_rddata (rd_w[g])
`ifdef KEY_SEARCH_STATS_EN
      ,
      .keys_tried (kt_w[g])
`endif
    );
  end

  function automatic logic [7:0] pt_byte(input int i, input logic [23:0] k, input logic [7:0] a);
    if (k < 24'd64) return ptab[i][k[5:0]][a];
    return (a == 8'd0) ? 8'd1 : 8'd0;
  endfunction

  function automatic bit ok_key(input int i, input logic [23:0] k);
    int len;
    len = int'(pt_byte(i, k, 8'd0));
    for (int a = 1; a <= len; a++) begin
      logic [7:0] b;
      b = pt_byte(i, k, 8'(a));
      if (b < 8'h20 || b > 8'h7E) return 1'b0;
    end
    return 1'b1;
  endfunction

  // First passing key in start, start+step, ... <= end
  function automatic void model(input int i, output bit found,
                                output logic [23:0] k, output int trials);
    longint cur;
    cur    = longint'(P_START[i]);
    trials = 0;
    found  = 1'b0;
    k      = P_START[i];
    while (trials < 100000) begin
      trials++;
      k = 24'(cur);
      if (ok_key(i, k)) begin
        found = 1'b1;
        return;
      end
      cur = cur + longint'(P_STEP[i]);
      if (cur > longint'(P_END[i])) return;
    end
  endfunction

  // arc4 + registered plaintext memory model
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < N; i++) begin
        a4rdy[i] <= 1'b1;
        busy[i]  <= 0;
      end
    end else begin
      for (int i = 0; i < N; i++) begin
        rd_w[i] <= pt_byte(i, run_key[i], addr_w[i]);
        if (a4en_w[i]) begin
          pulses[i]  <= pulses[i] + 1;
          run_key[i] <= a4key_w[i];
          if (i == 3) tried3.push_back(a4key_w[i]);
          if (a4rdy[i]) begin
            a4rdy[i] <= 1'b0;
            busy[i]  <= int'($urandom_range(2, 5));
          end
        end else if (!a4rdy[i]) begin
          if (busy[i] <= 1) a4rdy[i] <= 1'b1;
          else busy[i] <= busy[i] - 1;
        end
      end
    end
  end

  task automatic wait_rdy(input int i);
    for (int c = 0; c < 20000 && !rdy_w[i]; c++) @(negedge clk);
    if (!rdy_w[i]) begin
      n_checks++; n_errors++;
      $display("FAIL timeout_inst%0d: rdy=%0b, expected 1", i, rdy_w[i]);
    end
  endtask

  task automatic run(input int i);
    @(negedge clk); en_w[i] = 1'b1;
    @(negedge clk); en_w[i] = 1'b0;
    wait_rdy(i);
  endtask

  task automatic test_reset();
    repeat (2) @(negedge clk);
    for (int i = 0; i < N; i++) begin
      n_checks++; if (rdy_w[i] !== 1'b1) begin n_errors++; $display("FAIL reset_rdy%0d: got %0b, expected 1", i, rdy_w[i]); end
      n_checks++; if (kv_w[i] !== 1'b0) begin n_errors++; $display("FAIL reset_kv%0d: got %0b, expected 0", i, kv_w[i]); end
      n_checks++; if (a4en_w[i] !== 1'b0) begin n_errors++; $display("FAIL reset_a4en%0d: got %0b, expected 0", i, a4en_w[i]); end
      n_checks++; if (key_w[i] !== P_START[i]) begin n_errors++; $display("FAIL reset_key%0d: got %h, expected %h", i, key_w[i], P_START[i]); end
      n_checks++; if (addr_w[i] !== 8'd0) begin n_errors++; $display("FAIL reset_addr%0d: got %0d, expected 0", i, addr_w[i]); end
    end
    @(negedge clk); rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic load_known();
    ptab[0][0][0] = 8'd3; ptab[0][0][1] = "A"; ptab[0][0][2] = "B"; ptab[0][0][3] = 8'h07;
    ptab[0][1][0] = 8'd3; ptab[0][1][1] = "C"; ptab[0][1][2] = "a"; ptab[0][1][3] = "t";
  endtask

  task automatic test_known();
    int base;
    load_known();
    base = pulses[0];
    run(0);
    n_checks++; if (pulses[0] - base !== 2) begin n_errors++; $display("FAIL known_pulses: got %0d, expected 2", pulses[0] - base); end
    n_checks++; if (key_w[0] !== 24'h000001) begin n_errors++; $display("FAIL known_key: got %h, expected 000001", key_w[0]); end
    n_checks++; if (kv_w[0] !== 1'b1) begin n_errors++; $display("FAIL known_kv: got %0b, expected 1", kv_w[0]); end
    n_checks++; if (rdy_w[0] !== 1'b1) begin n_errors++; $display("FAIL known_rdy: got %0b, expected 1", rdy_w[0]); end
`ifdef KEY_SEARCH_STATS_EN
    n_checks++; if (kt_w[0] !== 25'd2) begin n_errors++; $display("FAIL known_stats: got %0d, expected 2", kt_w[0]); end
`endif
  endtask

  task automatic test_busy_en();
    int base;
    load_known();
    base = pulses[0];
    @(negedge clk); en_w[0] = 1'b1;
    repeat (6) @(negedge clk);
    en_w[0] = 1'b0;
    wait_rdy(0);
    repeat (20) @(negedge clk);
    n_checks++; if (pulses[0] - base !== 2) begin n_errors++; $display("FAIL busy_pulses: got %0d, expected 2", pulses[0] - base); end
    n_checks++; if (key_w[0] !== 24'h000001 || kv_w[0] !== 1'b1) begin n_errors++; $display("FAIL busy_result: got key=%h kv=%0b, expected key=000001 kv=1", key_w[0], kv_w[0]); end
    // re-request from DONE
    en_w[0] = 1'b1;
    @(posedge clk); #1;
    n_checks++; if (kv_w[0] !== 1'b0) begin n_errors++; $display("FAIL restart_kv: got %0b, expected 0", kv_w[0]); end
    n_checks++; if (key_w[0] !== P_START[0]) begin n_errors++; $display("FAIL restart_key: got %h, expected %h", key_w[0], P_START[0]); end
    n_checks++; if (rdy_w[0] !== 1'b0) begin n_errors++; $display("FAIL restart_rdy: got %0b, expected 0", rdy_w[0]); end
    base = pulses[0];
    @(negedge clk); en_w[0] = 1'b0;
    wait_rdy(0);
    n_checks++; if (pulses[0] - base !== 2) begin n_errors++; $display("FAIL restart_pulses: got %0d, expected 2", pulses[0] - base); end
    n_checks++; if (key_w[0] !== 24'h000001 || kv_w[0] !== 1'b1) begin n_errors++; $display("FAIL restart_result: got key=%h kv=%0b, expected key=000001 kv=1", key_w[0], kv_w[0]); end
`ifdef KEY_SEARCH_STATS_EN
    n_checks++; if (kt_w[0] !== 25'd2) begin n_errors++; $display("FAIL restart_stats: got %0d, expected 2", kt_w[0]); end
`endif
  endtask

  task automatic test_len_zero();
    int base;
    ptab[1][5][0] = 8'd0;
    base = pulses[1];
    run(1);
    n_checks++; if (pulses[1] - base !== 1) begin n_errors++; $display("FAIL len0_pulses: got %0d, expected 1", pulses[1] - base); end
    n_checks++; if (key_w[1] !== 24'd5 || kv_w[1] !== 1'b1) begin n_errors++; $display("FAIL len0_result: got key=%h kv=%0b, expected key=000005 kv=1", key_w[1], kv_w[1]); end
  endtask

  task automatic test_range_end();
    int base;
    base = pulses[2];
    run(2);
    n_checks++; if (pulses[2] - base !== 2) begin n_errors++; $display("FAIL range_pulses: got %0d, expected 2", pulses[2] - base); end
    n_checks++; if (key_w[2] !== 24'hFFFFFF || kv_w[2] !== 1'b0) begin n_errors++; $display("FAIL range_result: got key=%h kv=%0b, expected key=ffffff kv=0", key_w[2], kv_w[2]); end
    n_checks++; if (rdy_w[2] !== 1'b1) begin n_errors++; $display("FAIL range_rdy: got %0b, expected 1", rdy_w[2]); end
`ifdef KEY_SEARCH_STATS_EN
    n_checks++; if (kt_w[2] !== 25'd2) begin n_errors++; $display("FAIL range_stats: got %0d, expected 2", kt_w[2]); end
`endif
  endtask

  task automatic test_step();
    int base, qbase, trials;
    bit found;
    logic [23:0] ek;
    ptab[3][4][0] = 8'd2; ptab[3][4][1] = "o"; ptab[3][4][2] = "k";
    model(3, found, ek, trials);
    base  = pulses[3];
    qbase = tried3.size();
    run(3);
    n_checks++; if (pulses[3] - base !== trials) begin n_errors++; $display("FAIL step_pulses: got %0d, expected %0d", pulses[3] - base, trials); end
    n_checks++; if (key_w[3] !== ek || kv_w[3] !== found) begin n_errors++; $display("FAIL step_result: got key=%h kv=%0b, expected key=%h kv=%0b", key_w[3], kv_w[3], ek, found); end
    for (int j = 0; j < trials && qbase + j < tried3.size(); j++) begin
      logic [23:0] exp_k;
      exp_k = P_START[3] + 24'(j) * P_STEP[3];
      n_checks++; if (tried3[qbase + j] !== exp_k) begin n_errors++; $display("FAIL step_key%0d: got %h, expected %h", j, tried3[qbase + j], exp_k); end
    end
  endtask

  task automatic test_random();
    logic [7:0] bad  [5] = '{8'h00, 8'h1F, 8'h7F, 8'h80, 8'hFF};
    logic [7:0] good [3] = '{8'h20, 8'h7E, 8'h41};
    for (int it = 0; it < 6; it++) begin
      int t, base, trials;
      bit found;
      logic [7:0] ek;
      logic [23:0] ekey;
      t = int'($urandom_range(0, 20));
      for (int k = 0; k < 32; k++) begin
        int len, badpos;
        len = (k == t) ? int'($urandom_range(0, 8)) : int'($urandom_range(1, 8));
        badpos = int'($urandom_range(1, len < 1 ? 1 : len));
        ptab[0][k][0] = 8'(len);
        for (int a = 1; a <= len; a++) begin
          if (k < t && a == badpos) ptab[0][k][a] = bad[$urandom_range(0, 4)];
          else if ($urandom_range(0, 1) == 0) ptab[0][k][a] = good[$urandom_range(0, 2)];
          else ptab[0][k][a] = 8'($urandom_range(8'h20, 8'h7E));
        end
      end
      ek = 8'h00;
      model(0, found, ekey, trials);
      base = pulses[0];
      run(0);
      n_checks++; if (kv_w[0] !== found || key_w[0] !== ekey) begin n_errors++; $display("FAIL rand%0d_result: got key=%h kv=%0b, expected key=%h kv=%0b", it, key_w[0], kv_w[0], ekey, found); end
      n_checks++; if (pulses[0] - base !== trials) begin n_errors++; $display("FAIL rand%0d_pulses: got %0d, expected %0d", it, pulses[0] - base, trials); end
`ifdef KEY_SEARCH_STATS_EN
      n_checks++; if (kt_w[0] !== 25'(trials)) begin n_errors++; $display("FAIL rand%0d_stats: got %0d, expected %0d", it, kt_w[0], trials); end
`endif
      if (ek != 8'h00) $display("unexpected");
    end
  endtask

  task automatic test_reset_mid_scan();
    int base;
    bit seen;
    ptab[0][0][0] = 8'd2; ptab[0][0][1] = "x"; ptab[0][0][2] = 8'h00;
    seen = 1'b0;
    @(negedge clk); en_w[0] = 1'b1;
    @(negedge clk); en_w[0] = 1'b0;
    for (int c = 0; c < 200 && !seen; c++) begin
      @(posedge clk); #1;
      if (addr_w[0] == 8'd1) seen = 1'b1;
    end
    n_checks++; if (!seen) begin n_errors++; $display("FAIL midscan_reach: pt_addr=%0d, expected 1 within bound", addr_w[0]); end
    #2 rst = 1'b1;
    #1;
    n_checks++; if (rdy_w[0] !== 1'b1 || kv_w[0] !== 1'b0) begin n_errors++; $display("FAIL midscan_rdy_kv: got rdy=%0b kv=%0b, expected rdy=1 kv=0", rdy_w[0], kv_w[0]); end
    n_checks++; if (a4en_w[0] !== 1'b0) begin n_errors++; $display("FAIL midscan_a4en: got %0b, expected 0", a4en_w[0]); end
    n_checks++; if (key_w[0] !== P_START[0]) begin n_errors++; $display("FAIL midscan_key: got %h, expected %h", key_w[0], P_START[0]); end
    base = pulses[0];
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (30) @(negedge clk);
    n_checks++; if (pulses[0] - base !== 0) begin n_errors++; $display("FAIL midscan_pulses: got %0d, expected 0", pulses[0] - base); end
  endtask

  initial begin
    for (int i = 0; i < N; i++) begin
      en_w[i] = 1'b0;
      for (int k = 0; k < 64; k++) begin
        for (int a = 0; a < 256; a++) ptab[i][k][a] = 8'h00;
        ptab[i][k][0] = 8'd1;
      end
    end
    test_reset();
    test_known();
    test_busy_en();
    test_len_zero();
    test_range_end();
    test_step();
    test_random();
    test_reset_mid_scan();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #5000000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/key_search.md
Name: key_search

Overview:
- Brute-force key-search controller that sits directly upstream of the arc4 decryption core and drives its key and en/rdy handshake.
- For each candidate 24-bit key, starts arc4 and waits for completion. It then scans the length-prefixed plaintext memory that arc4 wrote.
- Stops at the first key whose every plaintext byte is printable ASCII, or when the key range is exhausted.
- The top level muxes pt_addr between arc4 (while arc4 busy) and this block.

Parameters:
- KEY_START, 24'h000000, first candidate key.
- KEY_END, 24'hFFFFFF, last candidate key (inclusive).
- KEY_STEP, 24'd1, stride between candidates; >1 lets N instances partition the space.
- ASCII_MIN, 8'h20, lowest accepted plaintext byte.
- ASCII_MAX, 8'h7E, highest accepted plaintext byte.

Ports:
- clk  input  1  system clock; one clock domain, all logic on rising edge.
- rst  input  1  asynchronous, active-high reset.
- en  input  1  start request, honoured only while rdy=1.
- rdy  output  1  high when idle/done and able to accept en.
- key  output  24  current candidate; after DONE, the found key if key_valid=1.
- key_valid  output  1  high in DONE when a key was found; low otherwise.
- arc4_en  output  1  one-cycle start pulse to arc4.
- arc4_rdy  input  1  arc4 ready/idle.
- arc4_key  output  24  key presented to arc4; always equals key.
- pt_addr  output  8  plaintext memory read address.
- pt_rddata  input  8  plaintext read data; registered memory, valid one cycle after pt_addr.

Behaviour:
- Reset (async, any state): state=IDLE, rdy=1, key=KEY_START, key_valid=0, arc4_en=0, pt_addr=0. An in-flight arc4 run is abandoned.
- Handshake: en is sampled only on an edge where rdy=1. On that edge rdy falls, key_valid clears, key loads KEY_START and state goes to START. en while rdy=0 is ignored.
- States:
  - IDLE: wait for en.
  - START: wait until arc4_rdy=1, then assert arc4_en for exactly one cycle.
  - WAIT_BUSY: wait for arc4_rdy=0.
  - WAIT_DONE: wait for arc4_rdy=1.
  - RD_LEN: drive pt_addr=0.
  - LATCH_LEN: capture len=pt_rddata, set idx=1. If len=0, go to FOUND.
  - RD_BYTE: drive pt_addr=idx.
  - CHK_BYTE: if pt_rddata is outside [ASCII_MIN, ASCII_MAX], go to NEXT_KEY. Else if idx==len, go to FOUND. Else idx++ and return to RD_BYTE.
  - NEXT_KEY: described below.
  - FOUND: key_valid=1, go to DONE.
  - DONE: rdy=1. key and key_valid hold until the next accepted en.
- NEXT_KEY arithmetic: compute key+KEY_STEP in 25 bits.
  - If the carry is set or the result exceeds KEY_END: exhausted, go to DONE with key_valid=0 and key unchanged.
  - Otherwise key updates and the state returns to START.
- idx is a 9-bit counter, so len=255 reads addresses 1..255 with no wrap.
- Scan latency: 2 cycles per byte. Per-key overhead beyond arc4 runtime: 4 cycles plus 2·len.
- KEY_START>KEY_END: after one trial of KEY_START, NEXT_KEY exhausts immediately.
- arc4_key is combinationally equal to key and is stable from START through WAIT_DONE.

Optional Feature:
- Macro KEY_SEARCH_STATS_EN.
- Defined: adds output port keys_tried [24:0].
  - Cleared on accepted en and on reset.
  - Incremented once per arc4_en pulse.
  - Held in DONE.
- Undefined: port and counter absent; behaviour otherwise identical.

Decomposition:
- Package key_search_pkg holds:
  - state enum (state_t);
  - PT_LEN_ADDR = 8'd0;
  - KEY_W = 24;
  - default ASCII bounds.
- One sub-module, pt_scanner, implements RD_LEN through CHK_BYTE:
  - inputs start, pt_rddata;
  - outputs pt_addr, done, pass.
- key_search keeps key iteration and the arc4 handshake.

Test Plan:
- Reset mid-scan (assert rst during RD_BYTE) -> same cycle: rdy=1, key_valid=0, arc4_en=0, key=KEY_START; no further arc4_en pulse.
- Behavioural arc4/memory model, KEY_START=0, pt for key 0 = {len=3,'A','B',8'h07}, pt for key 1 = {3,'C','a','t'}, en pulse -> exactly 2 arc4_en pulses; DONE with key=24'h000001, key_valid=1, rdy=1.
- len=0 for key 5, KEY_START=5 -> key_valid=1, key=5 after a single arc4 run.
- Range KEY_START=24'hFFFFFE, KEY_END=24'hFFFFFF, no key passes -> 2 arc4_en pulses, then DONE with key_valid=0, key=24'hFFFFFF; no overflow wrap to 0.
- KEY_STEP=2, KEY_START=1, pass at key 4 only -> keys 1,3,5,... tried; key 4 is never tried; exhausts at KEY_END.
- en held high while busy, and en re-asserted in DONE -> ignored while busy; in DONE, new search restarts at KEY_START, key_valid drops the following cycle. With KEY_SEARCH_STATS_EN defined, keys_tried matches the arc4_en pulse count.
